// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_fetch_pkg;

    // Default bus widths for the fetch path
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    // Common constant values
    localparam logic [InstBus-1:0] ZeroWord    = '0;
    localparam logic               ChipEnable  = 1'b1;
    localparam logic               ChipDisable = 1'b0;
    localparam logic               RstEnable   = 1'b1;

    // Sequential fetch advances one 32-bit word per instruction
    localparam int PcStep = 4;

    // Fetch FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries for decode.
// Latency: a pushed entry is visible at dout on the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; flush wins over push.
import inst_fetch_pkg::*;

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO can still accept a push when the head leaves in the same cycle
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign dout = mem[rd_ptr];

    // Storage array; entries are only meaningful while counted, so no reset
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : fetch_fifo

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the ROM, queues {pc, inst} for decode.
// Latency: word addressed in cycle N is at the head in cycle N+1 when the queue is empty.
// Backpressure: ready_i low holds entries; when full the PC and rom_addr freeze until a pop.
import inst_fetch_pkg::*;

module inst_fetch #(
    parameter int                ADDR_W   = InstAddrBus,
    parameter int                INST_W   = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);

    localparam int ENTRY_W = ADDR_W + INST_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_t         state;
    logic [ADDR_W-1:0]    pc;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ADDR_W-1:0]    branch_pc;

    // Redirect targets are word aligned regardless of the low address bits supplied
    assign branch_pc = {branch_target_i[ADDR_W-1:2], 2'b00};

    assign rom_addr = pc;

    // Handshake: decode takes the head whenever it is valid and ready
    assign valid_o = ~fifo_empty;
    assign pop     = valid_o & ready_i;

    // Fetch only in FETCH, never on a redirect cycle (the addressed word is stale),
    // and only when the queue has room after any same-cycle pop
    assign push = (state == FETCH) & ~branch_flag_i & (~fifo_full | pop);

    assign fifo_din = {pc, rom_inst};

    // Head fields are zeroed while nothing valid is presented
    assign pc_o   = valid_o ? fifo_dout[ENTRY_W-1:INST_W] : '0;
    assign inst_o = valid_o ? fifo_dout[INST_W-1:0]       : '0;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_flag_i),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch FSM: one idle cycle with the ROM disabled after reset, then fetch forever
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state  <= IDLE;
            rom_ce <= ChipDisable;
        end else begin
            case (state)
                IDLE: begin
                    state  <= FETCH;
                    rom_ce <= ChipEnable;
                end
                FETCH: begin
                    state  <= FETCH;
                    rom_ce <= ChipEnable;
                end
                default: begin
                    state  <= IDLE;
                    rom_ce <= ChipDisable;
                end
            endcase
        end
    end

    // PC: redirect wins, otherwise advance only when the current word was captured
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc <= RESET_PC;
        end else if (branch_flag_i) begin
            pc <= branch_pc;
        end else if (push) begin
            pc <= pc + ADDR_W'(PcStep);
        end
    end

    // Occupancy can never exceed the configured depth
    always_ff @(posedge clk) begin
        if (rst != RstEnable) begin
            assert (fifo_count <= CNT_W'(DEPTH))
                else $error("fetch queue occupancy exceeded depth");
        end
    end

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce          (rom_ce),
        .rom_addr        (rom_addr),
        .rom_inst        (rom_inst),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o)
    );

    // ROM contents: a distinct word per address
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h7E11};
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

    // Reference model: a queue of fetched PCs, the next fetch address and a started flag
    logic [31:0] m_q[$];
    logic [31:0] m_pc      = 32'h0;
    bit          m_fetch   = 1'b0;
    bit          m_known   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare all outputs with the model, then advance the model
    task automatic step(input logic r, input logic b, input logic [31:0] t, input logic rd);
        logic        exp_v;
        bit          pop;
        @(negedge clk);
        rst             = r;
        branch_flag_i   = b;
        branch_target_i = t;
        ready_i         = rd;
        #1;
        if (m_known) begin
            exp_v = (m_q.size() > 0);
            check("valid_o",  {31'b0, valid_o}, {31'b0, exp_v});
            check("pc_o",     pc_o,   exp_v ? m_q[0] : 32'h0);
            check("inst_o",   inst_o, exp_v ? rom_word(m_q[0]) : 32'h0);
            check("rom_ce",   {31'b0, rom_ce}, {31'b0, m_fetch});
            check("rom_addr", rom_addr, m_pc);
        end
        if (r) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_fetch = 1'b0;
            m_known = 1'b1;
        end else begin
            pop = (m_q.size() > 0) && rd;
            if (pop) void'(m_q.pop_front());
            if (b) begin
                m_q.delete();
                m_pc = t & 32'hFFFF_FFFC;
            end else if (m_fetch && m_q.size() < DEPTH) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            m_fetch = 1'b1;
        end
    endtask

    initial begin
        // Reset for 3 cycles, then stream with ready high
        repeat (3) step(1, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        check("ce_low_after_release", {31'b0, rom_ce}, 32'h0);
        step(0, 0, 32'h0, 1);
        check("first_fetch_addr", rom_addr, 32'h0);
        step(0, 0, 32'h0, 1);
        check("first_valid", {31'b0, valid_o}, 32'h1);
        check("first_pc", pc_o, 32'h0);
        check("first_inst", inst_o, rom_word(32'h0));
        step(0, 0, 32'h0, 1);
        check("second_pc", pc_o, 32'h4);
        step(0, 0, 32'h0, 1);
        check("third_pc", pc_o, 32'h8);
        check("third_inst", inst_o, rom_word(32'h8));

        // Decode stalls for 5 cycles from reset release: two entries held, address frozen
        repeat (2) step(1, 0, 32'h0, 0);
        repeat (5) step(0, 0, 32'h0, 0);
        check("stall_addr_frozen", rom_addr, 32'h8);
        check("stall_head_pc", pc_o, 32'h0);
        step(0, 0, 32'h0, 1);
        check("resume_pc0", pc_o, 32'h0);
        step(0, 0, 32'h0, 1);
        check("resume_pc4", pc_o, 32'h4);
        step(0, 0, 32'h0, 1);
        check("resume_pc8", pc_o, 32'h8);

        // Full queue (0x10, 0x14) redirected to unaligned 0x103 with decode stalled
        step(0, 1, 32'h10, 0);
        repeat (3) step(0, 0, 32'h0, 0);
        check("full_head", pc_o, 32'h10);
        check("full_addr", rom_addr, 32'h18);
        step(0, 1, 32'h103, 0);
        step(0, 0, 32'h0, 0);
        check("redirect_flush_valid", {31'b0, valid_o}, 32'h0);
        check("redirect_aligned_addr", rom_addr, 32'h100);
        step(0, 0, 32'h0, 0);
        check("redirect_first_pc", pc_o, 32'h100);

        // Redirect to 0x200 in the same cycle decode takes head 0x20
        step(0, 1, 32'h20, 0);
        repeat (3) step(0, 0, 32'h0, 0);
        step(0, 1, 32'h200, 1);
        check("pop_on_branch_valid", {31'b0, valid_o}, 32'h1);
        check("pop_on_branch_pc", pc_o, 32'h20);
        step(0, 0, 32'h0, 1);
        check("after_pop_branch_empty", {31'b0, valid_o}, 32'h0);
        step(0, 0, 32'h0, 1);
        check("after_pop_branch_pc", pc_o, 32'h200);

        // Address wrap at the top of the space
        step(0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        check("wrap_pc0", pc_o, 32'hFFFF_FFF8);
        step(0, 0, 32'h0, 1);
        check("wrap_pc1", pc_o, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1);
        check("wrap_pc2", pc_o, 32'h0000_0000);

        // Reset beats a simultaneous redirect with entries held
        step(0, 1, 32'h40, 0);
        repeat (3) step(0, 0, 32'h0, 0);
        check("pre_reset_head", pc_o, 32'h40);
        step(1, 1, 32'h300, 0);
        step(0, 0, 32'h0, 1);
        check("reset_flush_valid", {31'b0, valid_o}, 32'h0);
        check("reset_ce_low", {31'b0, rom_ce}, 32'h0);
        check("reset_pc", rom_addr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        b;
            logic        rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 63) == 0);
            b  = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 3) != 0);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r, b, t, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch
